// File: rtl/ifmap_row_writer_pkg.sv
// Shared types and helpers for the IFmap row writer: FSM encoding, tag bit
// positions and the width of the tagged IF word.
package ifmap_row_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DONE
  } state_t;

  // IF word = {sor, eor, pixel}
  function automatic int if_word_width(input int data_w);
    return data_w + 2;
  endfunction

  function automatic int sor_bit(input int data_w);
    return data_w + 1;
  endfunction

  function automatic int eor_bit(input int data_w);
    return data_w;
  endfunction

endpackage

// File: rtl/ifmap_row_writer_if.sv
// Pixel stream in and IF FIFO port out, bundled for the row writer.
// slave = the writer; master = the pixel source / FIFO side.
interface ifmap_row_writer_if #(
  parameter int W = 16
) ();

  logic                                           src_valid;
  logic [W-1:0]                                   src_data;
  logic                                           src_ready;
  logic                                           IF_wen;
  logic [ifmap_row_writer_pkg::if_word_width(W)-1:0] IF_din;
  logic                                           IF_full;

  modport slave (
    input  src_valid, src_data, IF_full,
    output src_ready, IF_wen, IF_din
  );

  modport master (
    output src_valid, src_data, IF_full,
    input  src_ready, IF_wen, IF_din
  );

endinterface

// File: rtl/ifmap_row_writer_row_col_counter.sv
// Column/row position within a frame; flags the first and last pixel of a row
// and the last pixel of the frame for the current (not yet written) word.
module ifmap_row_writer_row_col_counter #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  input  logic [LEN_W-1:0] row_len,
  input  logic [LEN_W-1:0] num_rows,
  output logic             col_first,
  output logic             col_last,
  output logic             frame_last
);

  logic [LEN_W-1:0] col_cnt;
  logic [LEN_W-1:0] row_cnt;
  logic [LEN_W-1:0] row_len_m1;
  logic [LEN_W-1:0] num_rows_m1;

  assign row_len_m1  = row_len - LEN_W'(1);
  assign num_rows_m1 = num_rows - LEN_W'(1);

  assign col_first  = (col_cnt == '0);
  assign col_last   = (col_cnt == row_len_m1);
  assign frame_last = col_last && (row_cnt == num_rows_m1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (clear) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (advance) begin
      if (col_last) begin
        col_cnt <= '0;
        row_cnt <= row_cnt + LEN_W'(1);
      end else begin
        col_cnt <= col_cnt + LEN_W'(1);
      end
    end
  end

endmodule

// File: rtl/ifmap_row_writer.sv
// Tags source pixels with start/end-of-row flags and pushes them into the
// IFmap FIFO under IF_full backpressure, for a programmed rows x row_len frame.
module ifmap_row_writer
  import ifmap_row_writer_pkg::*;
#(
  parameter int IF_SCRATCH_WIDTH = 16,
  parameter int LEN_W            = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [LEN_W-1:0]       row_len,
  input  logic [LEN_W-1:0]       num_rows,
  ifmap_row_writer_if.slave      bus,
  output logic                   busy,
  output logic                   done,
  output logic                   cfg_err
);

  localparam int WORD_W  = if_word_width(IF_SCRATCH_WIDTH);
  localparam int SOR_BIT = sor_bit(IF_SCRATCH_WIDTH);
  localparam int EOR_BIT = eor_bit(IF_SCRATCH_WIDTH);

  state_t           state;
  logic [LEN_W-1:0] row_len_q;
  logic [LEN_W-1:0] num_rows_q;
  logic             cfg_ok;
  logic             accept;
  logic             streaming;
  logic             xfer;
  logic             col_first;
  logic             col_last;
  logic             frame_last;
  logic [WORD_W-1:0] din;

  assign cfg_ok    = (row_len != '0) && (num_rows != '0);
  assign accept    = (state == ST_IDLE) && start && cfg_ok;
  assign streaming = (state == ST_STREAM);

  // Status decodes straight from the state register so reset clears them
  // immediately, without waiting for an edge.
  assign busy = streaming;
  assign done = (state == ST_DONE);

  // Zero-latency handshake: the FIFO write happens in the accepting cycle.
  assign bus.src_ready = streaming && !bus.IF_full;
  assign xfer          = bus.src_ready && bus.src_valid;
  assign bus.IF_wen    = xfer;
  assign bus.IF_din    = din;

  // NOTE: every always_comb output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    din = '0;
    if (streaming) begin
      din[IF_SCRATCH_WIDTH-1:0] = bus.src_data;
      din[SOR_BIT]              = col_first;
      din[EOR_BIT]              = col_last;
    end
  end

  ifmap_row_writer_row_col_counter #(
    .LEN_W (LEN_W)
  ) u_counter (
    .clk        (clk),
    .rst        (rst),
    .clear      (accept),
    .advance    (xfer),
    .row_len    (row_len_q),
    .num_rows   (num_rows_q),
    .col_first  (col_first),
    .col_last   (col_last),
    .frame_last (frame_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      row_len_q  <= '0;
      num_rows_q <= '0;
      cfg_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              row_len_q  <= row_len;
              num_rows_q <= num_rows;
              state      <= ST_STREAM;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        ST_STREAM: begin
          if (xfer && frame_last) state <= ST_DONE;
        end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule
